// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and its preset editor:
// BCD geometry, digit indices, per-digit limits and editor state encoding.
package timer_pkg;

  localparam int unsigned NUM_DIGITS = 9;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;
  localparam int unsigned CURSOR_W   = 4;

  localparam int unsigned DIG_MS1 = 0;
  localparam int unsigned DIG_MS2 = 1;
  localparam int unsigned DIG_MS3 = 2;
  localparam int unsigned DIG_S1  = 3;
  localparam int unsigned DIG_S2  = 4;
  localparam int unsigned DIG_M1  = 5;
  localparam int unsigned DIG_M2  = 6;
  localparam int unsigned DIG_H1  = 7;
  localparam int unsigned DIG_H2  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Tens-of-seconds and tens-of-minutes digits roll over at 5; all others at 9.
  function automatic logic [DIGIT_W-1:0] digit_max(input logic [CURSOR_W-1:0] k);
    if (k == CURSOR_W'(DIG_S2) || k == CURSOR_W'(DIG_M2)) return DIGIT_W'(5);
    return DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment/decrement with wrap inside [0, max]; up wins over down.
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W-1:0] max,
  input  logic               up,
  input  logic               down,
  output logic [DIGIT_W-1:0] next_c
);

  always_comb begin
    next_c = digit;
    if (up) begin
      next_c = (digit == max) ? DIGIT_W'(0) : digit + DIGIT_W'(1);
    end else if (down) begin
      next_c = (digit == DIGIT_W'(0)) ? max : digit - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/timer_preset_editor.sv
// Button-driven hh:mm:ss.mmm preset editor with cursor blink mask and a
// valid/ready load handshake toward the countdown timer.
module timer_preset_editor
  import timer_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 50_000_000
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  btn_l_i,
  input  logic                  btn_r_i,
  input  logic                  btn_u_i,
  input  logic                  btn_d_i,
  input  logic                  btn_c_i,
  input  logic                  load_ready_i,
  output logic [BCD_W-1:0]      preset_o,
  output logic                  load_valid_o,
  output logic                  editing_o,
  output logic [NUM_DIGITS-1:0] blink_mask_o
);

  localparam int unsigned CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CURSOR_W-1:0] CURSOR_HOME = CURSOR_W'(DIG_S1);

  state_e                state_q, state_d;
  logic [BCD_W-1:0]      preset_d;
  logic [CURSOR_W-1:0]   cursor_q, cursor_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic                  valid_d;
  logic                  editing_d;
  logic [NUM_DIGITS-1:0] mask_d;

  logic [DIGIT_W-1:0]    cur_digit_c;
  logic [DIGIT_W-1:0]    step_digit_c;
  logic [5:0]            digit_lsb_c;

  assign digit_lsb_c = {cursor_q, 2'b00};
  assign cur_digit_c = preset_o[digit_lsb_c +: DIGIT_W];

  bcd_digit_step u_step (
    .digit  (cur_digit_c),
    .max    (digit_max(cursor_q)),
    .up     (btn_u_i),
    .down   (btn_d_i),
    .next_c (step_digit_c)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      preset_o     <= '0;
      cursor_q     <= CURSOR_HOME;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      load_valid_o <= 1'b0;
      editing_o    <= 1'b0;
      blink_mask_o <= '0;
    end else begin
      state_q      <= state_d;
      preset_o     <= preset_d;
      cursor_q     <= cursor_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      load_valid_o <= valid_d;
      editing_o    <= editing_d;
      blink_mask_o <= mask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_o;
    cursor_d  = cursor_q;
    cnt_d     = '0;
    phase_d   = 1'b0;
    valid_d   = 1'b0;
    editing_d = 1'b0;
    mask_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (btn_c_i) begin
          state_d  = ST_EDIT;
          cursor_d = CURSOR_HOME;
        end
      end

      ST_EDIT: begin
        // Free-running blink, overridden below when the user acts on a digit.
        if (cnt_q == CNT_W'(BLINK_HALF - 1)) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          phase_d = phase_q;
        end

        if (btn_c_i) begin
          if (preset_o != '0) begin
            state_d = ST_COMMIT;
            valid_d = 1'b1;
          end
        end else if (btn_u_i || btn_d_i) begin
          preset_d[digit_lsb_c +: DIGIT_W] = step_digit_c;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (btn_l_i) begin
          cursor_d = (cursor_q == CURSOR_W'(DIG_H2)) ? CURSOR_W'(DIG_MS1)
                                                     : cursor_q + CURSOR_W'(1);
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (btn_r_i) begin
          cursor_d = (cursor_q == CURSOR_W'(DIG_MS1)) ? CURSOR_W'(DIG_H2)
                                                      : cursor_q - CURSOR_W'(1);
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end

      ST_COMMIT: begin
        if (load_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    editing_d = (state_d == ST_EDIT);
    if (state_d == ST_EDIT && phase_d) begin
      mask_d = NUM_DIGITS'(1) << cursor_d;
    end
  end

endmodule

// File: tb/tb_timer_preset_editor.sv
// Directed bench for timer_preset_editor with a short blink period.
module tb_timer_preset_editor;
  import timer_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  reset = 1'b1;
  logic                  btn_l_i = 1'b0;
  logic                  btn_r_i = 1'b0;
  logic                  btn_u_i = 1'b0;
  logic                  btn_d_i = 1'b0;
  logic                  btn_c_i = 1'b0;
  logic                  load_ready_i = 1'b0;
  logic [BCD_W-1:0]      preset_o;
  logic                  load_valid_o;
  logic                  editing_o;
  logic [NUM_DIGITS-1:0] blink_mask_o;

  int vectors = 0;
  int miscompares = 0;

  timer_preset_editor #(.BLINK_HALF(4)) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .btn_l_i      (btn_l_i),
    .btn_r_i      (btn_r_i),
    .btn_u_i      (btn_u_i),
    .btn_d_i      (btn_d_i),
    .btn_c_i      (btn_c_i),
    .load_ready_i (load_ready_i),
    .preset_o     (preset_o),
    .load_valid_o (load_valid_o),
    .editing_o    (editing_o),
    .blink_mask_o (blink_mask_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One-cycle button pulse {u,d,l,r,c}; outputs are sampled 1 time unit after the edge.
  task automatic press(input logic u, input logic d, input logic l, input logic r, input logic c);
    btn_u_i = u; btn_d_i = d; btn_l_i = l; btn_r_i = r; btn_c_i = c;
    @(posedge clk_i);
    #1;
    btn_u_i = 1'b0; btn_d_i = 1'b0; btn_l_i = 1'b0; btn_r_i = 1'b0; btn_c_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (preset_o !== 36'h0 || load_valid_o !== 1'b0 || editing_o !== 1'b0 || blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL reset: preset=%h valid=%b editing=%b mask=%h, want 0/0/0/0",
               preset_o, load_valid_o, editing_o, blink_mask_o);
    end
    press(1, 0, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h0 || editing_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore_u: preset=%h editing=%b, want 0/0", preset_o, editing_o);
    end
  endtask

  task automatic test_zero_commit();
    press(0, 0, 0, 0, 1);
    vectors++;
    if (editing_o !== 1'b1 || blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL enter_edit: editing=%b mask=%h, want 1/000", editing_o, blink_mask_o);
    end
    press(0, 0, 0, 0, 1);
    idle(1);
    vectors++;
    if (editing_o !== 1'b1 || load_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_commit: editing=%b valid=%b, want 1/0", editing_o, load_valid_o);
    end
  endtask

  task automatic test_increment();
    for (int i = 0; i < 3; i++) press(1, 0, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h000003000 || editing_o !== 1'b1) begin
      miscompares++;
      $display("FAIL inc_s1: preset=%h editing=%b, want 000003000/1", preset_o, editing_o);
    end
  endtask

  task automatic test_wrap();
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) press(1, 0, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h000003000) begin
      miscompares++;
      $display("FAIL s2_wrap_up: preset=%h, want 000003000", preset_o);
    end
    press(0, 1, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h000053000) begin
      miscompares++;
      $display("FAIL s2_wrap_down: preset=%h, want 000053000", preset_o);
    end
  endtask

  task automatic test_cursor_blink();
    press(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) press(0, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h100053000 || blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL h2_inc: preset=%h mask=%h, want 100053000/000", preset_o, blink_mask_o);
    end
    idle(3);
    vectors++;
    if (blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL blink_phase0: mask=%h, want 000", blink_mask_o);
    end
    idle(1);
    vectors++;
    if (blink_mask_o !== 9'h100) begin
      miscompares++;
      $display("FAIL blink_phase1: mask=%h, want 100", blink_mask_o);
    end
    idle(3);
    vectors++;
    if (blink_mask_o !== 9'h100) begin
      miscompares++;
      $display("FAIL blink_phase1_hold: mask=%h, want 100", blink_mask_o);
    end
    idle(1);
    vectors++;
    if (blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL blink_back_phase0: mask=%h, want 000", blink_mask_o);
    end
    idle(4);
    press(1, 0, 0, 0, 0);
    vectors++;
    if (blink_mask_o !== 9'h0 || preset_o !== 36'h200053000) begin
      miscompares++;
      $display("FAIL blink_restart: mask=%h preset=%h, want 000/200053000", blink_mask_o, preset_o);
    end
    idle(3);
    vectors++;
    if (blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL blink_restart_count: mask=%h, want 000", blink_mask_o);
    end
  endtask

  task automatic test_priority();
    press(1, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h400053000) begin
      miscompares++;
      $display("FAIL u_over_l: preset=%h, want 400053000", preset_o);
    end
    press(0, 1, 1, 1, 0);
    vectors++;
    if (preset_o !== 36'h300053000) begin
      miscompares++;
      $display("FAIL d_over_lr: preset=%h, want 300053000", preset_o);
    end
  endtask

  task automatic test_build_preset();
    do_reset();
    press(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) press(0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) press(0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) press(0, 1, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h012345678) begin
      miscompares++;
      $display("FAIL build_preset: preset=%h, want 012345678", preset_o);
    end
  endtask

  task automatic test_commit_hold();
    int bad;
    press(1, 0, 0, 0, 1);
    vectors++;
    if (load_valid_o !== 1'b1 || editing_o !== 1'b0 || blink_mask_o !== 9'h0 || preset_o !== 36'h012345678) begin
      miscompares++;
      $display("FAIL commit_enter: valid=%b editing=%b mask=%h preset=%h, want 1/0/000/012345678",
               load_valid_o, editing_o, blink_mask_o, preset_o);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      press(1, 1, 1, 1, 1);
      if (load_valid_o !== 1'b1 || preset_o !== 36'h012345678) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL commit_hold: %0d of 10 cycles lost valid or preset, want 0", bad);
    end
    load_ready_i = 1'b1;
    idle(1);
    load_ready_i = 1'b0;
    vectors++;
    if (load_valid_o !== 1'b0 || editing_o !== 1'b0 || preset_o !== 36'h012345678) begin
      miscompares++;
      $display("FAIL transfer: valid=%b editing=%b preset=%h, want 0/0/012345678",
               load_valid_o, editing_o, preset_o);
    end
    press(1, 0, 0, 0, 0);
    idle(2);
    vectors++;
    if (load_valid_o !== 1'b0 || editing_o !== 1'b0 || preset_o !== 36'h012345678) begin
      miscompares++;
      $display("FAIL idle_after_transfer: valid=%b editing=%b preset=%h, want 0/0/012345678",
               load_valid_o, editing_o, preset_o);
    end
  endtask

  task automatic test_back_to_back();
    press(0, 0, 0, 0, 1);
    press(1, 0, 0, 0, 0);
    vectors++;
    if (editing_o !== 1'b1 || preset_o !== 36'h012346678) begin
      miscompares++;
      $display("FAIL reenter_cursor_home: editing=%b preset=%h, want 1/012346678", editing_o, preset_o);
    end
    press(0, 0, 0, 0, 1);
    vectors++;
    if (load_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL second_commit: valid=%b, want 1", load_valid_o);
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    vectors++;
    if (load_valid_o !== 1'b0 || preset_o !== 36'h0 || editing_o !== 1'b0 || blink_mask_o !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_in_commit: valid=%b preset=%h editing=%b mask=%h, want 0/0/0/000",
               load_valid_o, preset_o, editing_o, blink_mask_o);
    end
    press(1, 0, 0, 0, 0);
    vectors++;
    if (preset_o !== 36'h0 || editing_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: preset=%h editing=%b, want 0/0", preset_o, editing_o);
    end
  endtask

  initial begin
    test_reset();
    test_zero_commit();
    test_increment();
    test_wrap();
    test_cursor_blink();
    test_priority();
    test_build_preset();
    test_commit_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
